clock_display_scan: RTL and testbench

- Downstream consumer of the 12-hour clock core.
- Takes the core's binary hours (1-12), minutes (0-59) and AM/PM flag.
- Converts them to BCD with a sequential double-dabble engine and drives a 4-digit multiplexed seven-segment display (HH:MM).
- Shows the colon and the PM indicator on decimal points.

---
 rtl/clock_disp_pkg.sv | 49 ++++
 rtl/clock_display_scan_bcd.sv | 50 +++++
 rtl/clock_display_scan.sv | 227 ++++++++++++++++++++++
 tb/tb_clock_display_scan.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the HH:MM seven-segment scanner.
package clock_disp_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_H = 2'd1,
        ST_CONV_M = 2'd2,
        ST_COMMIT = 2'd3
    } disp_state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

    // Digit positions on the display, left to right.
    localparam logic [1:0] DIG_HOUR_TENS = 2'd0;
    localparam logic [1:0] DIG_HOUR_ONES = 2'd1;
    localparam logic [1:0] DIG_MIN_TENS  = 2'd2;
    localparam logic [1:0] DIG_MIN_ONES  = 2'd3;

    // BCD digit to segment pattern; non-decimal codes show nothing.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_scan_bcd.sv
// Sequential double-dabble: 6-bit binary to two BCD digits in 6 shift cycles.
// The start edge performs the first shift directly on 'bin', so a new
// conversion can begin on the edge right after the previous one finished.
// busy: shifts 2..6 still to come; last: the coming edge does shift 6;
// done: result in tens/ones is complete (held until the next start).
module bcd_dabble6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       last,
    output logic       done
);

    // {tens[3:0], ones[3:0], remaining binary[5:0]}
    logic [13:0] sr;
    logic [2:0]  cnt;

    function automatic logic [13:0] dabble_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

    // One adjust-and-shift per cycle; cnt holds the number of shifts done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= dabble_step({8'd0, bin});
            cnt <= 3'd1;
        end else if (cnt != 3'd0 && cnt != 3'd6) begin
            sr  <= dabble_step(sr);
            cnt <= cnt + 3'd1;
        end
    end

    assign tens = sr[13:10];
    assign ones = sr[9:6];
    assign busy = (cnt != 3'd0) && (cnt != 3'd6);
    assign last = (cnt == 3'd5);
    assign done = (cnt == 3'd6);

endmodule

// File: rtl/clock_display_scan.sv
// HH:MM multiplexed seven-segment driver for the 12-hour clock core.
// Samples are converted to BCD one field at a time and committed to the
// display registers in a single edge, so a half-updated time is never shown.
import clock_disp_pkg::*;

module clock_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int COMMON_ANODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hours,
    input  logic [5:0] minutes,
    input  logic       am_pm,
    input  logic       update,
    input  logic       tick_1hz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en,
    output logic       busy,
    output logic       err
);

    localparam int         PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
    localparam logic       POL       = (COMMON_ANODE != 0);

    disp_state_t state, state_nxt;

    // Latest sample from the core (overwritten by every update).
    logic [3:0] hold_hours;
    logic [5:0] hold_minutes;
    logic       hold_pm;
    logic       hold_bad;
    logic       pending;

    // Snapshot of the sample being converted in the current pass.
    logic [5:0] work_minutes;
    logic       work_pm;
    logic       work_bad;
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;

    // Shared BCD engine.
    logic       eng_start;
    logic [5:0] eng_bin;
    logic [3:0] eng_tens;
    logic [3:0] eng_ones;
    logic       eng_busy;
    logic       eng_last;
    logic       eng_done;
    logic       commit_en;

    // Committed display contents.
    logic [6:0] disp_seg [4];
    logic       disp_pm;
    logic       err_r;
    logic       colon;

    // Scan timing and registered outputs (pre-polarity).
    logic [PW-1:0] pre, pre_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [3:0]    en_r;
    logic          dp_sel;

    bcd_dabble6 u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .bin   (eng_bin),
        .tens  (eng_tens),
        .ones  (eng_ones),
        .busy  (eng_busy),
        .last  (eng_last),
        .done  (eng_done)
    );

    // Sequencer next state: hours pass, minutes pass, then one commit edge.
    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_bin   = {2'b00, hold_hours};
        commit_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (update) state_nxt = ST_CONV_H;
            end
            ST_CONV_H: begin
                eng_bin   = {2'b00, hold_hours};
                eng_start = !eng_busy;
                if (eng_last) state_nxt = ST_CONV_M;
            end
            ST_CONV_M: begin
                eng_bin   = work_minutes;
                eng_start = !eng_busy;
                if (eng_last) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (eng_done) begin
                    commit_en = 1'b1;
                    state_nxt = (pending || update) ? ST_CONV_H : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Sample capture, pending flag and per-pass snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_hours   <= '0;
            hold_minutes <= '0;
            hold_pm      <= 1'b0;
            hold_bad     <= 1'b0;
            pending      <= 1'b0;
            work_minutes <= '0;
            work_pm      <= 1'b0;
            work_bad     <= 1'b0;
            hour_tens    <= '0;
            hour_ones    <= '0;
        end else begin
            if (update) begin
                hold_hours   <= hours;
                hold_minutes <= minutes;
                hold_pm      <= am_pm;
                hold_bad     <= (hours == 4'd0) || (hours > 4'd12) || (minutes > 6'd59);
            end
            // A commit consumes the pending request; an update arriving on
            // that same edge is picked up directly by the sequencer.
            if (commit_en)
                pending <= 1'b0;
            else if (update && state != ST_IDLE)
                pending <= 1'b1;
            // Freeze the rest of the sample when its hours start converting.
            if (state == ST_CONV_H && eng_start) begin
                work_minutes <= hold_minutes;
                work_pm      <= hold_pm;
                work_bad     <= hold_bad;
            end
            // Park the hours result while the engine moves on to minutes.
            if (state == ST_CONV_M && eng_start) begin
                hour_tens <= eng_tens;
                hour_ones <= eng_ones;
            end
        end
    end

    // Atomic display update: four digit codes, PM flag and err together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) disp_seg[i] <= SEG_BLANK;
            disp_pm <= 1'b0;
            err_r   <= 1'b0;
        end else if (commit_en) begin
            if (work_bad) begin
                for (int i = 0; i < 4; i++) disp_seg[i] <= SEG_DASH;
                disp_pm <= 1'b0;
                err_r   <= 1'b1;
            end else begin
                disp_seg[DIG_HOUR_TENS] <= (hour_tens == 4'd0) ? SEG_BLANK : seg_of_digit(hour_tens);
                disp_seg[DIG_HOUR_ONES] <= seg_of_digit(hour_ones);
                disp_seg[DIG_MIN_TENS]  <= seg_of_digit(eng_tens);
                disp_seg[DIG_MIN_ONES]  <= seg_of_digit(eng_ones);
                disp_pm <= work_pm;
                err_r   <= 1'b0;
            end
        end
    end

    // Colon blink phase follows the 1 Hz tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           colon <= 1'b0;
        else if (tick_1hz) colon <= ~colon;
    end

    // Scan counters' next values and the dp bit for the next digit slot.
    always_comb begin
        pre_nxt = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        idx_nxt = (pre == PRE_LAST) ? idx + 2'd1 : idx;
        dp_sel  = 1'b0;
        case (idx_nxt)
            DIG_HOUR_ONES: dp_sel = colon && !err_r;
            DIG_MIN_ONES:  dp_sel = disp_pm;
            default:       dp_sel = 1'b0;
        endcase
    end

    // Prescaler, scan index and the registered digit/segment outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            idx   <= '0;
            en_r  <= '0;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b0;
        end else begin
            pre <= pre_nxt;
            idx <= idx_nxt;
            if (pre_nxt < BLANK_LIM) begin
                en_r  <= '0;
                seg_r <= SEG_BLANK;
                dp_r  <= 1'b0;
            end else begin
                en_r  <= 4'b0001 << idx_nxt;
                seg_r <= disp_seg[idx_nxt];
                dp_r  <= dp_sel;
            end
        end
    end

    assign seg      = seg_r ^ {7{POL}};
    assign dp       = dp_r ^ POL;
    assign digit_en = en_r ^ {4{POL}};
    assign busy     = (state != ST_IDLE);
    assign err      = err_r;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: two instances share all inputs,
// one common-cathode and one common-anode, both scanning 8 cycles per digit.
module tb_clock_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] hours = '0;
    logic [5:0] minutes = '0;
    logic       am_pm = 1'b0;
    logic       update = 1'b0;
    logic       tick_1hz = 1'b0;

    logic [6:0] a_seg, b_seg;
    logic       a_dp, b_dp;
    logic [3:0] a_en, b_en;
    logic       a_busy, b_busy, a_err, b_err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] S_BL = 7'b0000000;
    localparam logic [6:0] S_DA = 7'b1000000;
    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S9 = 7'b1101111;

    logic [6:0] exp345 [4];

    clock_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(0)) dut_a (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .am_pm(am_pm),
        .update(update), .tick_1hz(tick_1hz), .seg(a_seg), .dp(a_dp),
        .digit_en(a_en), .busy(a_busy), .err(a_err)
    );

    clock_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(1)) dut_b (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .am_pm(am_pm),
        .update(update), .tick_1hz(tick_1hz), .seg(b_seg), .dp(b_dp),
        .digit_en(b_en), .busy(b_busy), .err(b_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a sample; returns just after the capturing edge N.
    task automatic do_update(input logic [3:0] h, input logic [5:0] m, input logic pm);
        hours = h; minutes = m; am_pm = pm; update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Wait for the conversion to finish, then one edge for the outputs.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && a_busy; i++) tick();
        check(tag, 32'(a_busy), 32'd0);
        tick();
    endtask

    // Wait for digit k's slot and check its segments and decimal point.
    task automatic expect_digit(input string tag, input int k, input logic [6:0] es, input logic ed);
        logic [3:0] want;
        bit found;
        want  = 4'b0001 << k;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (a_en == want) found = 1;
            else tick();
        end
        check({tag, "/en"}, 32'(a_en), 32'(want));
        check({tag, "/seg"}, 32'(a_seg), 32'(es));
        check({tag, "/dp"}, 32'(a_dp), 32'(ed));
    endtask

    function automatic int en_idx(input logic [3:0] e);
        for (int i = 0; i < 4; i++) if (e[i]) return i;
        return 0;
    endfunction

    initial begin
        int busy_cnt;
        int idx0;
        logic [3:0] prev_en, exp_en;
        bit synced;

        exp345[0] = S_BL; exp345[1] = S3; exp345[2] = S4; exp345[3] = S5;

        // Reset values, both polarities.
        #1 rst = 1'b1;
        #1;
        check("rst_a_seg", 32'(a_seg), 32'h00);
        check("rst_a_en", 32'(a_en), 32'h0);
        check("rst_a_dp", 32'(a_dp), 32'h0);
        check("rst_a_busy", 32'(a_busy), 32'h0);
        check("rst_a_err", 32'(a_err), 32'h0);
        check("rst_b_seg", 32'(b_seg), 32'h7f);
        check("rst_b_en", 32'(b_en), 32'hf);
        check("rst_b_dp", 32'(b_dp), 32'h1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 12:05 PM, busy for exactly 13 cycles.
        do_update(4'd12, 6'd5, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 40 && a_busy; i++) begin
            busy_cnt++;
            tick();
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd13);
        tick();
        check("t1_err", 32'(a_err), 32'd0);
        expect_digit("t1_d0", 0, S1, 1'b0);
        expect_digit("t1_d1", 1, S2, 1'b0);
        expect_digit("t1_d2", 2, S0, 1'b0);
        expect_digit("t1_d3", 3, S5, 1'b1);

        // 9:59 AM, hour tens blanked.
        do_update(4'd9, 6'd59, 1'b0);
        wait_idle("t2_idle");
        expect_digit("t2_d0", 0, S_BL, 1'b0);
        expect_digit("t2_d1", 1, S9, 1'b0);
        expect_digit("t2_d2", 2, S5, 1'b0);
        expect_digit("t2_d3", 3, S9, 1'b0);

        // 13:10 out of range: dashes, err set; then 1:00 clears it.
        do_update(4'd13, 6'd10, 1'b1);
        wait_idle("t3_idle");
        check("t3_err_set", 32'(a_err), 32'd1);
        for (int k = 0; k < 4; k++) expect_digit("t3_dash", k, S_DA, 1'b0);
        do_update(4'd1, 6'd0, 1'b0);
        wait_idle("t3b_idle");
        check("t3_err_clr", 32'(a_err), 32'd0);
        expect_digit("t3b_d0", 0, S_BL, 1'b0);
        expect_digit("t3b_d1", 1, S1, 1'b0);
        expect_digit("t3b_d2", 2, S0, 1'b0);
        expect_digit("t3b_d3", 3, S0, 1'b0);

        // Back-to-back: 11:11 at N, 3:45 PM at N+3.
        do_update(4'd11, 6'd11, 1'b0);
        for (int c = 0; c < 30; c++) begin
            check("t4_busy", 32'(a_busy), 32'(c <= 25));
            if (c >= 14 && c <= 26 && a_en != 4'd0)
                check("t4_first_seg", 32'(a_seg), 32'(S1));
            if (c >= 27 && a_en != 4'd0)
                check("t4_second_seg", 32'(a_seg), 32'(exp345[en_idx(a_en)]));
            if (c == 2) begin
                hours = 4'd3; minutes = 6'd45; am_pm = 1'b1; update = 1'b1;
            end
            if (c == 3) update = 1'b0;
            tick();
        end
        expect_digit("t4_d0", 0, S_BL, 1'b0);
        expect_digit("t4_d1", 1, S3, 1'b0);
        expect_digit("t4_d2", 2, S4, 1'b0);
        expect_digit("t4_d3", 3, S5, 1'b1);

        // Scan pattern: 6 active of 8, order 0,1,2,3, dark segments when off.
        synced = 0;
        for (int i = 0; i < 40 && !synced; i++) begin
            prev_en = a_en;
            tick();
            if (prev_en == 4'd0 && a_en != 4'd0) synced = 1;
        end
        idx0 = en_idx(a_en);
        for (int k = 0; k < 32; k++) begin
            exp_en = ((k % 8) < 6) ? (4'b0001 << ((idx0 + k / 8) % 4)) : 4'd0;
            check("t5_scan_en", 32'(a_en), 32'(exp_en));
            if (a_en == 4'd0) check("t5_blank_seg", 32'(a_seg), 32'd0);
            tick();
        end

        // Colon: off, then toggles on each tick.
        expect_digit("t5_colon0", 1, S3, 1'b0);
        tick_1hz = 1'b1; tick(); tick_1hz = 1'b0; tick();
        expect_digit("t5_colon1", 1, S3, 1'b1);
        tick_1hz = 1'b1; tick(); tick_1hz = 1'b0; tick();
        expect_digit("t5_colon2", 1, S3, 1'b0);
        tick_1hz = 1'b1; tick(); tick_1hz = 1'b0; tick();
        expect_digit("t5_colon3", 1, S3, 1'b1);

        // Reset in the middle of a conversion.
        do_update(4'd7, 6'd30, 1'b1);
        repeat (4) tick();
        check("t6_busy_before", 32'(a_busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t6_a_busy", 32'(a_busy), 32'd0);
        check("t6_a_en", 32'(a_en), 32'd0);
        check("t6_a_seg", 32'(a_seg), 32'd0);
        check("t6_b_busy", 32'(b_busy), 32'd0);
        check("t6_b_en", 32'(b_en), 32'hf);
        check("t6_b_seg", 32'(b_seg), 32'h7f);
        check("t6_b_dp", 32'(b_dp), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t6_post_busy", 32'(a_busy), 32'd0);
        check("t6_post_err", 32'(a_err), 32'd0);
        check("t6_post_b_busy", 32'(b_busy), 32'd0);
        for (int k = 0; k < 4; k++) expect_digit("t6_post_blank", k, S_BL, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
